// File: rtl/cep_uart_rx_monitor.sv
// UART 8N1 receiver with first-word-fall-through receive FIFO and error flags.
// Define CEP_UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module cep_uart_rx_monitor #(
   parameter int CLKS_PER_BIT = 1736,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              rxd,
   output logic [7:0]                        rx_data,
   output logic                              rx_valid,
   input  logic                              rx_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              frame_err,
   output logic                              parity_err,
   output logic                              overflow
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CW    = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]    DEPTH_C     = CW'(FIFO_DEPTH);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef CEP_UART_RX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
`endif
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   logic             rxd_meta_reg;
   logic             rxd_s_reg;
   logic [2:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic             push_pending_reg, push_pending_next;
   logic             frame_err_reg, frame_err_next;
   logic             par_bad;
`ifdef CEP_UART_RX_PARITY_EN
   logic             parity_bit_reg, parity_bit_next;
   logic             parity_err_reg, parity_err_next;
`endif

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             overflow_reg;
   logic             fifo_full;
   logic             do_pop;
   logic             do_push;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         rxd_meta_reg <= 1'b1;
         rxd_s_reg    <= 1'b1;
      end else begin
         rxd_meta_reg <= rxd;
         rxd_s_reg    <= rxd_meta_reg;
      end
   end

   always_comb begin
      state_next        = state_reg;
      cnt_next          = cnt_reg;
      bit_idx_next      = bit_idx_reg;
      shift_next        = shift_reg;
      push_pending_next = 1'b0;
      frame_err_next    = 1'b0;
      par_bad           = 1'b0;
`ifdef CEP_UART_RX_PARITY_EN
      parity_bit_next   = parity_bit_reg;
      parity_err_next   = 1'b0;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (!rxd_s_reg) begin
               state_next = ST_START;
               cnt_next   = HALF_RELOAD;
            end
         end
         ST_START: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else if (rxd_s_reg) begin
               state_next = ST_IDLE;
               cnt_next   = FULL_RELOAD;
            end else begin
               state_next   = ST_DATA;
               cnt_next     = FULL_RELOAD;
               bit_idx_next = 3'd0;
            end
         end
         ST_DATA: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
               shift_next   = {rxd_s_reg, shift_reg[7:1]};
               cnt_next     = FULL_RELOAD;
               bit_idx_next = bit_idx_reg + 3'd1;
               if (bit_idx_reg == 3'd7) begin
`ifdef CEP_UART_RX_PARITY_EN
                  state_next = ST_PARITY;
`else
                  state_next = ST_STOP;
`endif
               end
            end
         end
`ifdef CEP_UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
               parity_bit_next = rxd_s_reg;
               cnt_next        = FULL_RELOAD;
               state_next      = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
`ifdef CEP_UART_RX_PARITY_EN
               par_bad         = (^shift_reg) ^ parity_bit_reg;
               parity_err_next = par_bad;
`endif
               cnt_next = FULL_RELOAD;
               if (rxd_s_reg) begin
                  push_pending_next = !par_bad;
                  state_next        = ST_IDLE;
               end else begin
                  frame_err_next = 1'b1;
                  state_next     = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // A held-low line stays here so it reports only one framing error.
            if (rxd_s_reg) begin
               state_next = ST_IDLE;
               cnt_next   = FULL_RELOAD;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = FULL_RELOAD;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         cnt_reg          <= FULL_RELOAD;
         bit_idx_reg      <= 3'd0;
         shift_reg        <= 8'h00;
         push_pending_reg <= 1'b0;
         frame_err_reg    <= 1'b0;
`ifdef CEP_UART_RX_PARITY_EN
         parity_bit_reg   <= 1'b0;
         parity_err_reg   <= 1'b0;
`endif
      end else begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         bit_idx_reg      <= bit_idx_next;
         shift_reg        <= shift_next;
         push_pending_reg <= push_pending_next;
         frame_err_reg    <= frame_err_next;
`ifdef CEP_UART_RX_PARITY_EN
         parity_bit_reg   <= parity_bit_next;
         parity_err_reg   <= parity_err_next;
`endif
      end
   end

   // The shift register still holds the byte on the push cycle: IDLE never shifts.
   assign fifo_full = (count_reg == DEPTH_C);
   assign do_pop    = rx_valid & rx_ready;
   assign do_push   = push_pending_reg & (!fifo_full | do_pop);

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= shift_reg;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - 1'b1;
         end
         if (push_pending_reg && fifo_full && !do_pop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign rx_valid   = (count_reg != '0);
   assign rx_data    = rx_valid ? mem[rd_ptr_reg] : 8'h00;
   assign fifo_count = count_reg;
   assign frame_err  = frame_err_reg;
   assign overflow   = overflow_reg;
`ifdef CEP_UART_RX_PARITY_EN
   assign parity_err = parity_err_reg;
`else
   assign parity_err = 1'b0;
`endif

endmodule
